// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the 4-lane 7:1 LVDS transmit sequencer.
// Includes the PRBS7 word helper used by lvds_prbs7 when LVDS_PRBS_EN is defined.
package lvds_tx_pkg;

   localparam int LANES         = 4;
   localparam int BITS_PER_LANE = 7;
   localparam int WORD_W        = LANES * BITS_PER_LANE;

   localparam logic [BITS_PER_LANE-1:0] PRBS7_SEED    = 7'h7F;
   localparam logic [WORD_W-1:0]        TRAIN_PATTERN = {LANES{7'b0011110}};
   localparam logic [WORD_W-1:0]        IDLE_PATTERN  = 28'h0;

   typedef enum logic [2:0] {
      WAIT_LOCK,
      SER_RST,
      IDLE,
      TRAIN,
      RUN
   } tx_state_t;

   // Next 7 bits of x^7+x^6+1; bit 0 is the first generated (first sent).
   // The LFSR state after these 7 steps is this word bit-reversed.
   function automatic logic [BITS_PER_LANE-1:0] prbs7_word(input logic [BITS_PER_LANE-1:0] state);
      logic [BITS_PER_LANE-1:0] s;
      logic [BITS_PER_LANE-1:0] w;
      s = state;
      w = '0;
      for (int k = 0; k < BITS_PER_LANE; k++) begin
         w[k] = s[6] ^ s[5];
         s    = {s[5:0], w[k]};
      end
      return w;
   endfunction

endpackage

// File: rtl/lvds_prbs7.sv
// One-lane PRBS7 generator producing 7 bits per clock, with advance and reseed.
// Only instantiated when LVDS_PRBS_EN is defined.
module lvds_prbs7
   import lvds_tx_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     advance,
   input  logic                     reseed,
   output logic [BITS_PER_LANE-1:0] data
);

   logic [BITS_PER_LANE-1:0] lfsr_reg;
   logic [BITS_PER_LANE-1:0] lfsr_next;

   assign data = prbs7_word(lfsr_reg);

   always_comb begin
      lfsr_next = lfsr_reg;
      if (reseed) begin
         lfsr_next = PRBS7_SEED;
      end else if (advance) begin
         for (int k = 0; k < BITS_PER_LANE; k++) begin
            lfsr_next[BITS_PER_LANE-1-k] = data[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_reg <= PRBS7_SEED;
      end else begin
         lfsr_reg <= lfsr_next;
      end
   end

endmodule

// File: rtl/lvds_tx_ctrl.sv
// Sequencer/framer for the 4-lane 7:1 LVDS transmitter: lock wait, serdes reset, training, streaming.
// Optional PRBS7 test output is built when the macro LVDS_PRBS_EN is defined.
module lvds_tx_ctrl
   import lvds_tx_pkg::*;
#(
   parameter int LOCK_CYCLES  = 256,
   parameter int RST_CYCLES   = 16,
   parameter int TRAIN_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pll_locked,
   input  logic              tx_en,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [WORD_W-1:0] dat_out,
   output logic              serdes_rst,
   output logic              link_up,
   output logic [15:0]       underflow_cnt
`ifdef LVDS_PRBS_EN
   ,
   input  logic              prbs_mode
`endif
);

   localparam int MAX_CNT = (LOCK_CYCLES > RST_CYCLES) ?
                            ((LOCK_CYCLES > TRAIN_CYCLES) ? LOCK_CYCLES : TRAIN_CYCLES) :
                            ((RST_CYCLES > TRAIN_CYCLES) ? RST_CYCLES : TRAIN_CYCLES);
   localparam int CNT_W = $clog2(MAX_CNT);

   localparam logic [CNT_W-1:0] LOCK_LD  = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TRAIN_LD = CNT_W'(TRAIN_CYCLES - 1);

   tx_state_t         state_reg;
   tx_state_t         state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [CNT_W-1:0]  cnt_next;
   logic              lock_meta_reg;
   logic              lock_s_reg;
   logic [WORD_W-1:0] dat_out_reg;
   logic [WORD_W-1:0] dat_out_next;
   logic [15:0]       underflow_reg;
   logic [15:0]       underflow_next;
   logic              run_active;
   logic              prbs_active;
   logic              accept;

   // pll_locked is asynchronous to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_reg <= 1'b0;
         lock_s_reg    <= 1'b0;
      end else begin
         lock_meta_reg <= pll_locked;
         lock_s_reg    <= lock_meta_reg;
      end
   end

`ifdef LVDS_PRBS_EN
   logic              prbs_mode_reg;
   logic              prbs_reseed;
   logic [WORD_W-1:0] prbs_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prbs_mode_reg <= 1'b0;
      end else begin
         prbs_mode_reg <= prbs_mode;
      end
   end

   assign prbs_active = run_active && prbs_mode_reg;
   assign prbs_reseed = (state_next == RUN) && (state_reg != RUN);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         lvds_prbs7 u_prbs7 (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (prbs_active),
            .reseed  (prbs_reseed),
            .data    (prbs_word[gi*BITS_PER_LANE +: BITS_PER_LANE])
         );
      end
   endgenerate
`else
   assign prbs_active = 1'b0;
`endif

   // Gating with lock_s guarantees no beat is taken in the cycle lock loss forces WAIT_LOCK.
   assign run_active = (state_reg == RUN) && lock_s_reg;
   assign s_ready    = run_active && !prbs_active;
   assign accept     = s_valid && s_ready;
   assign link_up    = (state_reg == RUN);
   assign serdes_rst = (state_reg == WAIT_LOCK) || (state_reg == SER_RST);
   assign dat_out       = dat_out_reg;
   assign underflow_cnt = underflow_reg;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         WAIT_LOCK: begin
            if (!lock_s_reg) begin
               cnt_next = LOCK_LD;
            end else if (cnt_reg == '0) begin
               state_next = SER_RST;
               cnt_next   = RST_LD;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         SER_RST: begin
            if (cnt_reg == '0) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         IDLE: begin
            if (tx_en) begin
               state_next = TRAIN;
               cnt_next   = TRAIN_LD;
            end
         end
         TRAIN: begin
            if (!tx_en) begin
               state_next = IDLE;
            end else if (cnt_reg == '0) begin
               state_next = RUN;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         RUN: begin
            if (!tx_en) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = WAIT_LOCK;
            cnt_next   = LOCK_LD;
         end
      endcase

      // Lock loss overrides tx_en and any counter expiry.
      if ((state_reg != WAIT_LOCK) && !lock_s_reg) begin
         state_next = WAIT_LOCK;
         cnt_next   = LOCK_LD;
      end
   end

   always_comb begin
      dat_out_next = IDLE_PATTERN;
      if (state_next == TRAIN) begin
         dat_out_next = TRAIN_PATTERN;
      end else if (accept) begin
         dat_out_next = s_data;
      end
`ifdef LVDS_PRBS_EN
      else if (prbs_active) begin
         dat_out_next = prbs_word;
      end
`endif
   end

   always_comb begin
      underflow_next = underflow_reg;
      if ((state_reg == RUN) && !prbs_active && !s_valid && (underflow_reg != 16'hFFFF)) begin
         underflow_next = underflow_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= WAIT_LOCK;
         cnt_reg       <= LOCK_LD;
         dat_out_reg   <= IDLE_PATTERN;
         underflow_reg <= 16'd0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         dat_out_reg   <= dat_out_next;
         underflow_reg <= underflow_next;
      end
   end

endmodule

// File: tb/tb_lvds_tx_ctrl.sv
// Directed-vector bench for lvds_tx_ctrl: sequencing, lock loss, streaming, saturation, training abort.
// Adds a PRBS7 check when LVDS_PRBS_EN is defined.
module tb_lvds_tx_ctrl;

   localparam logic [27:0] TRAIN_PAT = 28'b0011110_0011110_0011110_0011110;
   localparam logic [27:0] IDLE_PAT  = 28'h0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pll_locked;
   logic        tx_en;
   logic [27:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [27:0] dat_out;
   logic        serdes_rst;
   logic        link_up;
   logic [15:0] underflow_cnt;
`ifdef LVDS_PRBS_EN
   logic        prbs_mode;
`endif

   int n_vec = 0;
   int n_err = 0;

   lvds_tx_ctrl u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pll_locked    (pll_locked),
      .tx_en         (tx_en),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .dat_out       (dat_out),
      .serdes_rst    (serdes_rst),
      .link_up       (link_up),
      .underflow_cnt (underflow_cnt)
`ifdef LVDS_PRBS_EN
      ,
      .prbs_mode     (prbs_mode)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Measures serdes_rst length, the single IDLE cycle and the TRAIN length, then expects RUN.
   task automatic wait_link(input string tag, input int exp_rst_len);
      int n;
      n = 0;
      while (serdes_rst && n < 2000) begin
         tick();
         n++;
      end
      chk({tag, "_rst_len"}, n, exp_rst_len);
      n = 0;
      while (dat_out != TRAIN_PAT && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_idle_len"}, n, 1);
      n = 0;
      while (dat_out == TRAIN_PAT && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_train_len"}, n, 64);
      chk({tag, "_link_up"}, link_up, 1);
      chk({tag, "_s_ready"}, s_ready, 1);
   endtask

`ifdef LVDS_PRBS_EN
   function automatic logic [6:0] ref_prbs(input logic [6:0] st, output logic [6:0] st_out);
      logic [6:0] w;
      logic       b;
      w = '0;
      for (int k = 0; k < 7; k++) begin
         b    = st[6] ^ st[5];
         w[k] = b;
         st   = {st[5:0], b};
      end
      st_out = st;
      return w;
   endfunction
`endif

   initial begin
      int n;
      rst_n      = 1'b0;
      pll_locked = 1'b1;
      tx_en      = 1'b1;
      s_data     = '0;
      s_valid    = 1'b0;
`ifdef LVDS_PRBS_EN
      prbs_mode  = 1'b0;
`endif

      // Reset state
      repeat (5) tick();
      chk("rst_serdes_rst", serdes_rst, 1);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_link_up", link_up, 0);
      chk("rst_dat_out", dat_out, IDLE_PAT);
      chk("rst_underflow", underflow_cnt, 0);
      rst_n = 1'b1;

      // Power-up: 256+2 lock wait plus 16 serdes reset, then 64 training words
      wait_link("pwrup", 274);

      // Streaming, latency 1, then a 3-cycle gap
      chk("run_underflow0", underflow_cnt, 0);
      s_data  = 28'h0ABCDEF;
      s_valid = 1'b1;
      tick();
      chk("beat0", dat_out, 28'h0ABCDEF);
      s_data = 28'h5555555;
      tick();
      chk("beat1", dat_out, 28'h5555555);
      s_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("gap_idle", dat_out, IDLE_PAT);
      end
      chk("gap_underflow", underflow_cnt, 3);

`ifdef LVDS_PRBS_EN
      begin
         logic [6:0] st;
         logic [6:0] w;
         prbs_mode = 1'b1;
         tick();
         chk("prbs_s_ready", s_ready, 0);
         st = 7'h7F;
         for (int k = 0; k < 130; k++) begin
            tick();
            w = ref_prbs(st, st);
            chk("prbs_word", dat_out, {4{w}});
         end
         chk("prbs_underflow", underflow_cnt, 4);
         prbs_mode = 1'b0;
         tick();
         tick();
         chk("prbs_off_ready", s_ready, 1);
      end
`endif

      // Lock glitch of one cycle; blocked beat during the state change
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      chk("glitch_ready_gate", s_ready, 0);
      s_data  = 28'h1234567;
      s_valid = 1'b1;
      tick();
      chk("glitch_serdes_rst", serdes_rst, 1);
      chk("glitch_s_ready", s_ready, 0);
      chk("glitch_link_up", link_up, 0);
      chk("glitch_no_beat", dat_out, IDLE_PAT);
      s_valid = 1'b0;
      wait_link("relock", 272);

      // tx_en drop on the last TRAIN cycle wins over counter expiry
      tx_en = 1'b0;
      tick();
      chk("txen_off_link", link_up, 0);
      tx_en = 1'b1;
      tick();
      chk("train_start", dat_out, TRAIN_PAT);
      repeat (63) tick();
      chk("train_last", dat_out, TRAIN_PAT);
      tx_en = 1'b0;
      tick();
      chk("abort_link", link_up, 0);
      chk("abort_dat", dat_out, IDLE_PAT);
      repeat (3) tick();
      chk("abort_stays", link_up, 0);
      tx_en = 1'b1;
      tick();
      n = 0;
      while (dat_out == TRAIN_PAT && n < 200) begin
         tick();
         n++;
      end
      chk("retrain_len", n, 64);
      chk("retrain_link", link_up, 1);

      // Saturation
      s_valid = 1'b0;
      repeat (70000) tick();
      chk("sat_value", underflow_cnt, 16'hFFFF);
      tick();
      chk("sat_holds", underflow_cnt, 16'hFFFF);
      tx_en = 1'b0;
      tick();
      chk("sat_idle_link", link_up, 0);
      repeat (5) tick();
      chk("sat_idle_hold", underflow_cnt, 16'hFFFF);

      // Asynchronous reset mid-beat
      tx_en = 1'b1;
      n = 0;
      while (!link_up && n < 200) begin
         tick();
         n++;
      end
      chk("reup_link", link_up, 1);
      s_data  = 28'h7654321;
      s_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_serdes_rst", serdes_rst, 1);
      chk("arst_s_ready", s_ready, 0);
      chk("arst_link_up", link_up, 0);
      chk("arst_dat_out", dat_out, IDLE_PAT);
      chk("arst_underflow", underflow_cnt, 0);
      tick();
      chk("arst_beat_dropped", dat_out, IDLE_PAT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
